mul8_dot_acc: RTL and testbench

//   Sequential accumulator that sits directly downstream of the 8x8 unsigned

---
 rtl/mul8_dot_acc.sv | 111 +++++++++++
 tb/tb_mul8_dot_acc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul8_dot_acc.sv
// mul8_dot_acc: sums 16-bit unsigned products from a mul8 multiplier into a
// dot-product result, framed by P_LAST, returned on a valid/ready stream.
//
// Optional feature macro: SATURATE_EN
//   defined   -> the accumulator clamps to all-ones on overflow
//   undefined -> the accumulator wraps modulo 2^ACC_W
// S_OVF reports the overflow in both builds.
//
// state | meaning
// IDLE  | no terms accepted yet; acc/cnt/ovf are zero
// ACC   | at least one term accepted, waiting for the P_LAST beat
// DONE  | result presented on S/S_CNT/S_OVF, waiting for S_READY

module mul8_dot_acc #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 9
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [15:0]      P,
  input  logic             P_VALID,
  input  logic             P_LAST,
  output logic             P_READY,
  output logic [ACC_W-1:0] S,
  output logic [CNT_W-1:0] S_CNT,
  output logic             S_OVF,
  output logic             S_VALID,
  input  logic             S_READY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;

  // Ready is a pure decode of the registered state, so S_READY never reaches it.
  assign P_READY = (state != DONE);

  // Next accumulator values for an accepted beat; the extra sum bit is the carry.
  always_comb begin
    sum     = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, P};
    ovf_nxt = ovf | sum[ACC_W];
`ifdef SATURATE_EN
    // Once clamped, acc is all-ones and ovf is sticky, so it stays clamped.
    acc_nxt = ovf_nxt ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_nxt = sum[ACC_W-1:0];
`endif
    cnt_nxt = (&cnt) ? cnt : cnt + CNT_ONE;
  end

  // Framing FSM with the accumulator and the registered result outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      S       <= '0;
      S_CNT   <= '0;
      S_OVF   <= 1'b0;
      S_VALID <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (P_VALID) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
            if (P_LAST) begin
              state   <= DONE;
              S       <= acc_nxt;
              S_CNT   <= cnt_nxt;
              S_OVF   <= ovf_nxt;
              S_VALID <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          // Result outputs keep their value after the handshake.
          if (S_READY) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            S_VALID <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_dot_acc.sv
// Bench for mul8_dot_acc (ACC_W=24, CNT_W=9). Expected results are queued when
// a vector is driven and compared when the result handshake happens.

module tb_mul8_dot_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] p_in = 16'h0;
  logic        p_valid = 1'b0;
  logic        p_last = 1'b0;
  logic        p_ready;
  logic [23:0] s;
  logic [8:0]  s_cnt;
  logic        s_ovf;
  logic        s_valid;
  logic        s_ready = 1'b1;

  typedef struct packed {
    logic [23:0] s;
    logic [8:0]  c;
    logic        o;
  } res_t;

  res_t        exp_q[$];
  logic [15:0] beats[$];
  int          total = 0;
  int          bad = 0;

  mul8_dot_acc #(.ACC_W(24), .CNT_W(9)) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .P       (p_in),
    .P_VALID (p_valid),
    .P_LAST  (p_last),
    .P_READY (p_ready),
    .S       (s),
    .S_CNT   (s_cnt),
    .S_OVF   (s_ovf),
    .S_VALID (s_valid),
    .S_READY (s_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Compare each result at the negedge before the edge that completes its handshake.
  always @(negedge clk) begin
    res_t e;
    if (rst_n && s_valid && s_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("s", s, e.s);
        chk("s_cnt", s_cnt, e.c);
        chk("s_ovf", s_ovf, e.o);
      end
    end
  end

  task automatic push_exp(input logic [23:0] es, input logic [8:0] ec, input logic eo);
    res_t e;
    e.s = es; e.c = ec; e.o = eo;
    exp_q.push_back(e);
  endtask

  // Called #1 after a clock edge; returns #1 after the edge that accepted the beat.
  task automatic send_beat(input logic [15:0] p, input logic last);
    int guard;
    guard = 0;
    p_in = p; p_valid = 1'b1; p_last = last;
    while (!p_ready && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!p_ready) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    p_valid = 1'b0; p_last = 1'b0;
  endtask

  task automatic send_beats(input int gap_at);
    for (int i = 0; i < beats.size(); i++) begin
      send_beat(beats[i], i == beats.size() - 1);
      if (i == gap_at) begin
        p_in = 16'hDEAD; p_last = 1'b1;
        @(posedge clk); #1;
        p_last = 1'b0;
      end
    end
    chk("latency_s_valid", s_valid, 1);
  endtask

  task automatic fill(input logic [15:0] p, input int n);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back(p);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_s", s, 0);
    chk("rst_s_cnt", s_cnt, 0);
    chk("rst_s_ovf", s_ovf, 0);
    chk("rst_s_valid", s_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_p_ready", p_ready, 1);
  endtask

  function automatic res_t model();
    logic [24:0] sum;
    res_t r;
    r = '0;
    for (int i = 0; i < beats.size(); i++) begin
      sum = {1'b0, r.s} + {9'd0, beats[i]};
      if (sum[24]) r.o = 1'b1;
`ifdef SATURATE_EN
      r.s = r.o ? 24'hFFFFFF : sum[23:0];
`else
      r.s = sum[23:0];
`endif
      if (r.c != 9'h1FF) r.c = r.c + 9'd1;
    end
    return r;
  endfunction

  initial begin
    res_t m;
    repeat (2) @(posedge clk);
    #1;
    chk("init_s_valid", s_valid, 0);
    chk("init_p_ready", p_ready, 1);
    do_reset();

    // small vector with a gap inside
    beats.delete();
    beats.push_back(16'h0001); beats.push_back(16'h0002); beats.push_back(16'h0003);
    push_exp(24'h000006, 9'd3, 1'b0);
    send_beats(1);
    drain();
    @(posedge clk); #1;
    chk("s_hold_after_hs", s, 24'h000006);
    chk("s_valid_drop", s_valid, 0);

    // largest non-overflowing sum
    fill(16'hFE01, 258);
    push_exp(24'hFFFD02, 9'd258, 1'b0);
    send_beats(-1);
    drain();

    // one more term overflows
    fill(16'hFE01, 259);
`ifdef SATURATE_EN
    push_exp(24'hFFFFFF, 9'd259, 1'b1);
`else
    push_exp(24'h00FB03, 9'd259, 1'b1);
`endif
    send_beats(-1);
    drain();

    // backpressure: stalled beat must not be accepted while in DONE
    s_ready = 1'b0;
    push_exp(24'h00FFFF, 9'd1, 1'b0);
    send_beat(16'hFFFF, 1'b1);
    p_in = 16'h1234; p_valid = 1'b1; p_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_s_valid", s_valid, 1);
      chk("bp_s", s, 24'h00FFFF);
      chk("bp_p_ready", p_ready, 0);
      @(posedge clk); #1;
    end
    push_exp(24'h001234, 9'd1, 1'b0);
    s_ready = 1'b1;
    send_beat(16'h1234, 1'b1);
    drain();

    // count saturation
    fill(16'h0000, 600);
    push_exp(24'h000000, 9'h1FF, 1'b0);
    send_beats(-1);
    drain();

    // reset while a result is pending
    s_ready = 1'b0;
    beats.delete();
    beats.push_back(16'h0007); beats.push_back(16'h0008);
    send_beats(-1);
    do_reset();
    s_ready = 1'b1;

    // reset mid-vector
    send_beat(16'h0009, 1'b0);
    send_beat(16'h0009, 1'b0);
    do_reset();
    beats.delete();
    beats.push_back(16'h0005);
    push_exp(24'h000005, 9'd1, 1'b0);
    send_beats(-1);
    drain();

    // random vectors against the reference sum
    for (int v = 0; v < 4; v++) begin
      beats.delete();
      for (int i = 0; i < int'($urandom_range(1, 30)); i++)
        beats.push_back(16'($urandom));
      m = model();
      push_exp(m.s, m.c, m.o);
      send_beats(int'($urandom_range(0, 3)) - 1);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
